// File: rtl/score_row_max_sub.sv
// score_row_max_sub
//   Streaming row normaliser feeding the softmax stage. It buffers one
//   attention-score row of ROW_LEN signed elements while tracking the row
//   maximum, then replays the row as sat(x - max), so every output is <= 0.
//   Load and drain are strictly sequential, one row in flight at a time.
//
// Ports
//   clk_p        rising-edge clock
//   rst_n        synchronous reset, active HIGH despite the name
//   in_data      signed score element
//   in_valid_n   active-low input valid
//   in_ready     active-high, block accepts in_data this cycle (LOAD only)
//   out_data     signed saturated (element - row max)
//   out_max      signed max of the row being drained
//   out_last     marks the final element of a row
//   out_valid_n  active-low output valid
//   out_ready    active-high downstream accept
module score_row_max_sub #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_LEN    = 128,
  parameter int CNT_WIDTH  = $clog2(ROW_LEN)
) (
  input  logic                  clk_p,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid_n,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0] out_max,
  output logic                  out_last,
  output logic                  out_valid_n,
  input  logic                  out_ready
);

  typedef enum logic {LOAD, DRAIN} state_e;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(ROW_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_e                                  state_q, state_d;
  logic [CNT_WIDTH-1:0]                    wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0]                    rd_cnt_q, rd_cnt_d;
  logic [DATA_WIDTH-1:0]                   row_max_q, row_max_d;
  logic [ROW_LEN-1:0][DATA_WIDTH-1:0]      row_buf_q, row_buf_d;

  logic                  drain_active;
  logic                  accept;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] rd_elem;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] sat_diff;

  // rst_n gates the handshake outputs so they read idle during the reset
  // cycle itself, not just after the reset edge.
  assign drain_active = (state_q == DRAIN) && !rst_n;
  assign in_ready     = (state_q == LOAD) && !rst_n;
  assign accept       = !in_valid_n && in_ready;
  assign xfer         = drain_active && out_ready;

  // Sign-extended subtract; the true range is [-(2^W - 1), 0] so only the
  // negative side can overflow. Overflow shows as the two top bits differing.
  assign rd_elem  = row_buf_q[rd_cnt_q];
  assign diff     = {rd_elem[DATA_WIDTH-1], rd_elem} -
                    {row_max_q[DATA_WIDTH-1], row_max_q};
  assign sat_diff = (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) ?
                    {1'b1, {(DATA_WIDTH-1){1'b0}}} : diff[DATA_WIDTH-1:0];

  assign out_valid_n = !drain_active;
  assign out_data    = drain_active ? sat_diff  : '0;
  assign out_max     = drain_active ? row_max_q : '0;
  assign out_last    = drain_active && (rd_cnt_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    row_max_d = row_max_q;
    row_buf_d = row_buf_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          row_buf_d[wr_cnt_q] = in_data;
          // First element seeds the max so stale values never leak in.
          if (wr_cnt_q == '0 || $signed(in_data) > $signed(row_max_q))
            row_max_d = in_data;
          wr_cnt_d = wr_cnt_q + CNT_ONE;
          if (wr_cnt_q == LAST_IDX) begin
            state_d  = DRAIN;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        if (xfer) begin
          rd_cnt_d = rd_cnt_q + CNT_ONE;
          if (rd_cnt_q == LAST_IDX) begin
            state_d  = LOAD;
            rd_cnt_d = '0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (rst_n) begin
      state_q   <= LOAD;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      row_max_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      row_max_q <= row_max_d;
    end
  end

  // Row storage is never observed before being rewritten, so it needs no reset.
  always_ff @(posedge clk_p) begin
    row_buf_q <= row_buf_d;
  end

endmodule
